sram_read_arbiter: RTL and testbench
====================================

SRAM_READ_ARBITER -- requirements
Module: sram_read_arbiter

Interface
REQ-001 The block SHALL expose parameters: ADDR_W, 20, SRAM word address width; DATA_W, 16, SRAM data width.
REQ-002 The block SHALL have exactly one clock; reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have the following ports, one per line:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_vga_req  in  1  VGA single-word read request
- i_vga_addr  in  ADDR_W  VGA read address
- o_vga_gnt  out  1  VGA request granted this cycle (combinational)
- o_vga_rvalid  out  1  o_rdata holds VGA data
- i_spr_req  in  2  sprite burst requests; bit0 = nemo, bit1 = kelly
- i_spr0_addr, i_spr1_addr  in  ADDR_W each  burst base addresses
- i_spr0_len, i_spr1_len  in  8 each  burst length in words; 0 means 256
- o_spr_gnt  out  2  one-cycle pulse when a burst is accepted
- o_spr_rvalid  out  2  o_rdata holds a sprite burst word
- o_spr_done  out  2  one-cycle pulse with the last word of a burst
- o_rdata  out  DATA_W  registered read data, shared by all requesters
- o_address  out  ADDR_W  registered SRAM address
- i_SRAMDATA  in  DATA_W  SRAM read data
- o_busy  out  1  high while a sprite burst is active

Function
REQ-004 One SRAM issue slot SHALL exist per cycle; the owner is VGA, spr0, spr1, or none.
REQ-005 VGA SHALL have absolute priority: o_vga_gnt = i_vga_req in every state; a granted cycle loads o_address <= i_vga_addr at the next edge.
REQ-006 The FSM SHALL have states IDLE, BURST0 and BURST1.
REQ-007 In IDLE with i_spr_req != 0, the block SHALL accept one requester and latch its base and length into internal registers.
- Selection: a single request wins; if both are set, the requester indicated by the round-robin pointer wins.
- The block SHALL pulse o_spr_gnt[k] and enter BURSTk.
- The accept cycle SHALL NOT issue a sprite read.
REQ-008 In BURSTk, each cycle with i_vga_req low SHALL issue base+offset, then increment offset.
REQ-009 A cycle in BURSTk with i_vga_req high SHALL stall the burst, preserving offset.
REQ-010 Address arithmetic SHALL be modulo 2^ADDR_W (wrap from 0xFFFFF to 0x00000).
REQ-011 After issuing offset = len-1 (255 for len 0), the FSM SHALL return to IDLE and set the round-robin pointer to the other requester.
REQ-012 i_spr_req and the length/address inputs SHALL be sampled only in IDLE; deasserting a request mid-burst SHALL NOT abort the burst.
REQ-013 Read return path:
- At the edge that loads o_address, a tag register SHALL record the slot owner.
- At the following edge, the block SHALL load o_rdata <= i_SRAMDATA and assert exactly one rvalid selected by the tag, for one cycle.
- Latency from grant cycle to rvalid cycle SHALL be 2 cycles.
REQ-014 o_spr_done[k] SHALL assert in the same cycle as the rvalid of the last burst word.
REQ-015 In no-owner cycles, o_address and o_rdata SHALL hold their values, the tag SHALL be none, and no rvalid SHALL assert.
REQ-016 o_busy SHALL be high exactly in BURST0/BURST1.
REQ-017 Back-to-back issue SHALL sustain one word per cycle; the next burst MAY be accepted in the cycle after returning to IDLE.

Reset
REQ-018 While i_rst_n is low, the block SHALL hold:
- FSM = IDLE, pointer = 0, offset = 0, tag = none
- o_address = 0, o_rdata = 0
- all rvalid, gnt and done outputs = 0, o_busy = 0
REQ-019 Reset asserted mid-burst SHALL abort the burst; no o_spr_done SHALL pulse, and no rvalid SHALL pulse for in-flight words.

Verification
REQ-020 The bench SHALL cover these scenarios:
- VGA only: req at 0x00100 in cycle t -> o_address = 0x00100 after edge t; o_vga_rvalid in cycle t+2 with i_SRAMDATA captured.
- spr0 len=4, base 0x20000, no VGA -> gnt pulse, addresses 0x20000..0x20003 on consecutive cycles, 4 rvalids, done with the 4th.
- Both sprites request in IDLE with pointer 0 -> spr0 served first, spr1 accepted right after; then both again -> spr0 served first.
- VGA req for 3 cycles mid-burst (len=8) -> burst stalls 3 cycles, all 8 words delivered in order, VGA words interleaved with correct tags.
- spr1 base 0xFFFFE, len=4 -> addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- len=0 -> 256 words, done on the 256th; reset after word 10 -> all outputs 0, no done.

Source files
------------

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter: shares one SRAM read port between a VGA single-word
// reader (absolute priority) and two sprite burst readers (round-robin).
//
// Ports:
//   i_clk, i_rst_n              clock, asynchronous active-low reset
//   i_vga_req, i_vga_addr       VGA single-word read request and address
//   o_vga_gnt                   VGA granted this cycle (combinational, = i_vga_req)
//   o_vga_rvalid                o_rdata holds VGA data
//   i_spr_req[1:0]              sprite burst requests (bit0 nemo, bit1 kelly)
//   i_spr0/1_addr, i_spr0/1_len burst base address and length (0 means 256)
//   o_spr_gnt[1:0]              one-cycle pulse in the first cycle of an accepted burst
//   o_spr_rvalid[1:0]           o_rdata holds a sprite burst word
//   o_spr_done[1:0]             pulses together with the rvalid of the last burst word
//   o_rdata                     registered read data (shared)
//   o_address                   registered SRAM address
//   i_SRAMDATA                  SRAM read data, valid in the cycle after o_address
//   o_busy                      high while a sprite burst is active
module sram_read_arbiter #(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_vga_req,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic              o_vga_gnt,
    output logic              o_vga_rvalid,
    input  logic [1:0]        i_spr_req,
    input  logic [ADDR_W-1:0] i_spr0_addr,
    input  logic [ADDR_W-1:0] i_spr1_addr,
    input  logic [7:0]        i_spr0_len,
    input  logic [7:0]        i_spr1_len,
    output logic [1:0]        o_spr_gnt,
    output logic [1:0]        o_spr_rvalid,
    output logic [1:0]        o_spr_done,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_address,
    input  logic [DATA_W-1:0] i_SRAMDATA,
    output logic              o_busy
);

    localparam int unsigned LEN_W = 8;

    typedef enum logic [1:0] {ST_IDLE, ST_BURST0, ST_BURST1} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_VGA, TAG_SPR0, TAG_SPR1} tag_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   off_q, off_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    tag_e               tag_q, tag_d;
    logic               last_q, last_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               vga_rv_q, vga_rv_d;
    logic [1:0]         spr_rv_q, spr_rv_d;
    logic [1:0]         done_q, done_d;
    logic               pick;

    // Issue slot ownership, burst sequencing and read-return pipeline.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        base_d   = base_q;
        len_d    = len_q;
        off_d    = off_q;
        addr_d   = addr_q;
        tag_d    = TAG_NONE;
        last_d   = 1'b0;
        gnt_d    = 2'b00;
        pick     = 1'b0;

        if (i_vga_req) begin
            addr_d = i_vga_addr;
            tag_d  = TAG_VGA;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_spr_req != 2'b00) begin
                    // Single request wins outright; a tie goes to the pointer.
                    pick   = (i_spr_req == 2'b11) ? rr_q : i_spr_req[1];
                    base_d = pick ? i_spr1_addr : i_spr0_addr;
                    len_d  = pick ? i_spr1_len : i_spr0_len;
                    off_d  = '0;
                    gnt_d  = pick ? 2'b10 : 2'b01;
                    state_d = pick ? ST_BURST1 : ST_BURST0;
                end
            end
            ST_BURST0, ST_BURST1: begin
                if (!i_vga_req) begin
                    addr_d = base_q + ADDR_W'(off_q);
                    tag_d  = (state_q == ST_BURST1) ? TAG_SPR1 : TAG_SPR0;
                    // len 0 wraps to 255 here, giving a 256-word burst.
                    if (off_q == len_q - LEN_W'(1)) begin
                        last_d  = 1'b1;
                        off_d   = '0;
                        rr_d    = (state_q == ST_BURST0);
                        state_d = ST_IDLE;
                    end else begin
                        off_d = off_q + LEN_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        rdata_d  = (tag_q != TAG_NONE) ? i_SRAMDATA : rdata_q;
        vga_rv_d = (tag_q == TAG_VGA);
        spr_rv_d = {tag_q == TAG_SPR1, tag_q == TAG_SPR0};
        done_d   = spr_rv_d & {2{last_q}};
    end

    // State and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= 1'b0;
            base_q   <= '0;
            len_q    <= '0;
            off_q    <= '0;
            addr_q   <= '0;
            tag_q    <= TAG_NONE;
            last_q   <= 1'b0;
            gnt_q    <= 2'b00;
            rdata_q  <= '0;
            vga_rv_q <= 1'b0;
            spr_rv_q <= 2'b00;
            done_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            base_q   <= base_d;
            len_q    <= len_d;
            off_q    <= off_d;
            addr_q   <= addr_d;
            tag_q    <= tag_d;
            last_q   <= last_d;
            gnt_q    <= gnt_d;
            rdata_q  <= rdata_d;
            vga_rv_q <= vga_rv_d;
            spr_rv_q <= spr_rv_d;
            done_q   <= done_d;
        end
    end

    assign o_vga_gnt    = i_vga_req;
    assign o_vga_rvalid = vga_rv_q;
    assign o_spr_gnt    = gnt_q;
    assign o_spr_rvalid = spr_rv_q;
    assign o_spr_done   = done_q;
    assign o_rdata      = rdata_q;
    assign o_address    = addr_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Self-checking bench for sram_read_arbiter: a table of per-cycle vectors for
// the VGA and simple burst cases, then hand-written multi-cycle sequences
// checked against an expected read-return log.
module tb_sram_read_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vga_req;
    logic [AW-1:0] vga_addr;
    logic          vga_gnt;
    logic          vga_rvalid;
    logic [1:0]    spr_req;
    logic [AW-1:0] spr0_addr, spr1_addr;
    logic [7:0]    spr0_len, spr1_len;
    logic [1:0]    spr_gnt, spr_rvalid, spr_done;
    logic [DW-1:0] rdata;
    logic [AW-1:0] address;
    logic [DW-1:0] sram_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // SRAM model: data is a fixed scramble of the address currently presented.
    function automatic logic [DW-1:0] sram_fn(input logic [AW-1:0] a);
        return a[15:0] ^ {a[19:16], 12'h000} ^ 16'h5A3C;
    endfunction

    assign sram_data = sram_fn(address);

    sram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_vga_req    (vga_req),
        .i_vga_addr   (vga_addr),
        .o_vga_gnt    (vga_gnt),
        .o_vga_rvalid (vga_rvalid),
        .i_spr_req    (spr_req),
        .i_spr0_addr  (spr0_addr),
        .i_spr1_addr  (spr1_addr),
        .i_spr0_len   (spr0_len),
        .i_spr1_len   (spr1_len),
        .o_spr_gnt    (spr_gnt),
        .o_spr_rvalid (spr_rvalid),
        .o_spr_done   (spr_done),
        .o_rdata      (rdata),
        .o_address    (address),
        .i_SRAMDATA   (sram_data),
        .o_busy       (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Read-return log: {who(0 vga,1 spr0,2 spr1), done, data}.
    logic [18:0] log_q[$];
    logic [18:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rvalid_onehot", 32'($countones({vga_rvalid, spr_rvalid}) <= 1), 32'd1);
            chk("done_needs_rvalid", 32'((spr_done & ~spr_rvalid) == 2'b00), 32'd1);
            if (vga_rvalid)    log_q.push_back({2'd0, 1'b0, rdata});
            if (spr_rvalid[0]) log_q.push_back({2'd1, spr_done[0], rdata});
            if (spr_rvalid[1]) log_q.push_back({2'd2, spr_done[1], rdata});
        end
    end

    task automatic ex(input logic [1:0] who, input logic [AW-1:0] a, input logic d);
        exp_q.push_back({who, d, sram_fn(a)});
    endtask

    task automatic compare_log(input string nm);
        int n;
        chk({nm, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_word%0d", nm, i), 32'(log_q[i]), 32'(exp_q[i]));
        log_q.delete();
        exp_q.delete();
    endtask

    task automatic idle_inputs();
        vga_req = 1'b0;
        spr_req = 2'b00;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_addr"},   32'(address), 32'h0);
        chk({nm, "_rdata"},  32'(rdata), 32'h0);
        chk({nm, "_rvalid"}, 32'({vga_rvalid, spr_rvalid}), 32'h0);
        chk({nm, "_gnt"},    32'(spr_gnt), 32'h0);
        chk({nm, "_done"},   32'(spr_done), 32'h0);
        chk({nm, "_busy"},   32'(busy), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset");
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
    endtask

    typedef struct {
        logic          vga_req;
        logic [AW-1:0] vga_addr;
        logic [1:0]    spr_req;
        logic [AW-1:0] s0_addr;
        logic [7:0]    s0_len;
        logic          e_vga_gnt;
        logic [AW-1:0] e_addr;
        logic          e_vga_rv;
        logic [1:0]    e_spr_rv;
        logic [1:0]    e_gnt;
        logic [1:0]    e_done;
        logic          e_busy;
        logic [DW-1:0] e_rdata;
    } vec_t;

    function automatic vec_t mk(input logic vr, input logic [AW-1:0] va, input logic [1:0] sr,
                                input logic [AW-1:0] sa, input logic [7:0] sl, input logic eg,
                                input logic [AW-1:0] ea, input logic evr, input logic [1:0] esr,
                                input logic [1:0] egn, input logic [1:0] ed, input logic eb,
                                input logic [DW-1:0] erd);
        vec_t v;
        v.vga_req = vr;  v.vga_addr = va; v.spr_req = sr; v.s0_addr = sa; v.s0_len = sl;
        v.e_vga_gnt = eg; v.e_addr = ea; v.e_vga_rv = evr; v.e_spr_rv = esr;
        v.e_gnt = egn; v.e_done = ed; v.e_busy = eb; v.e_rdata = erd;
        return v;
    endfunction

    vec_t vecs[10];

    initial begin
        // VGA single read, then spr0 len 4 at 0x20000; burst inputs are
        // scrambled after accept to show they are latched.
        vecs[0] = mk(1, 20'h00100, 2'b00, 20'h00000, 8'd0, 1, 20'h00100, 0, 2'b00, 2'b00, 2'b00, 0, 16'h0000);
        vecs[1] = mk(0, 20'h00000, 2'b00, 20'h00000, 8'd0, 0, 20'h00100, 1, 2'b00, 2'b00, 2'b00, 0, sram_fn(20'h00100));
        vecs[2] = mk(0, 20'h00000, 2'b00, 20'h00000, 8'd0, 0, 20'h00100, 0, 2'b00, 2'b00, 2'b00, 0, sram_fn(20'h00100));
        vecs[3] = mk(0, 20'h00000, 2'b01, 20'h20000, 8'd4, 0, 20'h00100, 0, 2'b00, 2'b01, 2'b00, 1, sram_fn(20'h00100));
        vecs[4] = mk(0, 20'h00000, 2'b00, 20'h07777, 8'd9, 0, 20'h20000, 0, 2'b00, 2'b00, 2'b00, 1, sram_fn(20'h00100));
        vecs[5] = mk(0, 20'h00000, 2'b00, 20'h07777, 8'd9, 0, 20'h20001, 0, 2'b01, 2'b00, 2'b00, 1, sram_fn(20'h20000));
        vecs[6] = mk(0, 20'h00000, 2'b00, 20'h07777, 8'd9, 0, 20'h20002, 0, 2'b01, 2'b00, 2'b00, 1, sram_fn(20'h20001));
        vecs[7] = mk(0, 20'h00000, 2'b00, 20'h07777, 8'd9, 0, 20'h20003, 0, 2'b01, 2'b00, 2'b00, 0, sram_fn(20'h20002));
        vecs[8] = mk(0, 20'h00000, 2'b00, 20'h07777, 8'd9, 0, 20'h20003, 0, 2'b01, 2'b00, 2'b01, 0, sram_fn(20'h20003));
        vecs[9] = mk(0, 20'h00000, 2'b00, 20'h07777, 8'd9, 0, 20'h20003, 0, 2'b00, 2'b00, 2'b00, 0, sram_fn(20'h20003));

        rst_n = 1'b0;
        vga_req = 1'b0; vga_addr = '0; spr_req = 2'b00;
        spr0_addr = '0; spr1_addr = '0; spr0_len = '0; spr1_len = '0;
        step(3);
        chk_reset_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        log_q.delete();

        for (int i = 0; i < 10; i++) begin
            vga_req   = vecs[i].vga_req;
            vga_addr  = vecs[i].vga_addr;
            spr_req   = vecs[i].spr_req;
            spr0_addr = vecs[i].s0_addr;
            spr0_len  = vecs[i].s0_len;
            #1;
            chk($sformatf("v%0d_vga_gnt", i), 32'(vga_gnt), 32'(vecs[i].e_vga_gnt));
            step(1);
            chk($sformatf("v%0d_addr", i),    32'(address), 32'(vecs[i].e_addr));
            chk($sformatf("v%0d_vga_rv", i),  32'(vga_rvalid), 32'(vecs[i].e_vga_rv));
            chk($sformatf("v%0d_spr_rv", i),  32'(spr_rvalid), 32'(vecs[i].e_spr_rv));
            chk($sformatf("v%0d_gnt", i),     32'(spr_gnt), 32'(vecs[i].e_gnt));
            chk($sformatf("v%0d_done", i),    32'(spr_done), 32'(vecs[i].e_done));
            chk($sformatf("v%0d_busy", i),    32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_rdata", i),   32'(rdata), 32'(vecs[i].e_rdata));
        end
        idle_inputs();
        step(2);
        log_q.delete();

        // Round-robin: both request with pointer 0 after reset.
        do_reset();
        log_q.delete();
        spr0_addr = 20'h30000; spr0_len = 8'd2;
        spr1_addr = 20'h40000; spr1_len = 8'd2;
        spr_req = 2'b11;
        step(1);
        chk("rr_first_gnt", 32'(spr_gnt), 32'h1);
        step(2);
        chk("rr_first_end_busy", 32'(busy), 32'h0);
        step(1);
        chk("rr_second_gnt", 32'(spr_gnt), 32'h2);
        spr_req = 2'b00;
        step(5);
        spr_req = 2'b11;
        step(1);
        chk("rr_third_gnt", 32'(spr_gnt), 32'h1);
        spr_req = 2'b00;
        step(6);
        ex(2'd1, 20'h30000, 1'b0); ex(2'd1, 20'h30001, 1'b1);
        ex(2'd2, 20'h40000, 1'b0); ex(2'd2, 20'h40001, 1'b1);
        ex(2'd1, 20'h30000, 1'b0); ex(2'd1, 20'h30001, 1'b1);
        compare_log("rr");

        // VGA stalls a len-8 burst for three cycles.
        spr0_addr = 20'h50000; spr0_len = 8'd8;
        spr_req = 2'b01;
        step(1);
        spr_req = 2'b00;
        step(2);
        for (int i = 0; i < 3; i++) begin
            vga_req = 1'b1;
            vga_addr = 20'h00A00 + 20'(i);
            #1;
            chk($sformatf("stall%0d_vga_gnt", i), 32'(vga_gnt), 32'h1);
            step(1);
            chk($sformatf("stall%0d_addr", i), 32'(address), 32'(20'h00A00 + 20'(i)));
            chk($sformatf("stall%0d_busy", i), 32'(busy), 32'h1);
        end
        vga_req = 1'b0;
        step(6);
        chk("stall_end_addr", 32'(address), 32'h50007);
        chk("stall_end_busy", 32'(busy), 32'h0);
        step(4);
        ex(2'd1, 20'h50000, 1'b0); ex(2'd1, 20'h50001, 1'b0);
        ex(2'd0, 20'h00A00, 1'b0); ex(2'd0, 20'h00A01, 1'b0); ex(2'd0, 20'h00A02, 1'b0);
        for (int i = 2; i < 8; i++) ex(2'd1, 20'h50000 + 20'(i), i == 7);
        compare_log("stall");

        // Address wrap on spr1.
        spr1_addr = 20'hFFFFE; spr1_len = 8'd4;
        spr_req = 2'b10;
        step(1);
        chk("wrap_gnt", 32'(spr_gnt), 32'h2);
        spr_req = 2'b00;
        step(1); chk("wrap_a0", 32'(address), 32'hFFFFE);
        step(1); chk("wrap_a1", 32'(address), 32'hFFFFF);
        step(1); chk("wrap_a2", 32'(address), 32'h00000);
        step(1); chk("wrap_a3", 32'(address), 32'h00001);
        step(4);
        ex(2'd2, 20'hFFFFE, 1'b0); ex(2'd2, 20'hFFFFF, 1'b0);
        ex(2'd2, 20'h00000, 1'b0); ex(2'd2, 20'h00001, 1'b1);
        compare_log("wrap");

        // len 0 is a 256-word burst.
        spr0_addr = 20'h60000; spr0_len = 8'd0;
        spr_req = 2'b01;
        step(1);
        spr_req = 2'b00;
        step(255);
        chk("len0_busy_before_last", 32'(busy), 32'h1);
        step(1);
        chk("len0_busy_after", 32'(busy), 32'h0);
        chk("len0_last_addr", 32'(address), 32'h600FF);
        step(4);
        for (int i = 0; i < 256; i++) ex(2'd1, 20'h60000 + 20'(i), i == 255);
        compare_log("len0");

        // Reset mid-burst after ten words have returned.
        spr0_addr = 20'h70000; spr0_len = 8'd0;
        spr_req = 2'b01;
        step(1);
        spr_req = 2'b00;
        step(11);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        step(2);
        chk_reset_outputs("midrst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        step(6);
        chk_reset_outputs("midrst_after");
        for (int i = 0; i < 10; i++) ex(2'd1, 20'h70000 + 20'(i), 1'b0);
        compare_log("midrst");

        // Pointer is back to 0 after reset: a tie goes to spr0.
        spr0_len = 8'd1; spr1_len = 8'd1;
        spr_req = 2'b11;
        step(1);
        chk("post_rst_tie_gnt", 32'(spr_gnt), 32'h1);
        spr_req = 2'b00;
        step(5);
        log_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
